// File: rtl/bpsk_tx_sched.sv
// bpsk_tx_sched: serialises N-bit codewords into signed BPSK symbols (+1 for 0, -1 for 1) over a ready/valid stream
module bpsk_tx_sched #(
  parameter int N = 4,
  parameter int SIZE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N-1:0]              cw_in,
  input  logic                      cw_valid,
  output logic                      cw_ready,
  output logic signed [SIZE-1:0]    sym_out,
  output logic                      sym_valid,
  input  logic                      sym_ready,
  output logic [$clog2(N)-1:0]      sym_idx,
  output logic                      sym_last,
  output logic                      busy,
  output logic [15:0]               frame_cnt
);
  localparam int W = $clog2(N);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [N-1:0] hold;
  logic xfer, acc, done;
  assign busy      = state == SEND && !rst;
  assign sym_valid = busy;
  assign sym_last  = sym_valid && sym_idx == W'(N - 1);
  assign sym_out   = !sym_valid ? '0 : hold[sym_idx] ? '1 : SIZE'(1);
  assign cw_ready  = (state == IDLE || (sym_last && sym_ready)) && !flush && !rst;
  assign xfer      = sym_valid && sym_ready;
  assign acc       = cw_valid && cw_ready;
  assign done      = xfer && sym_last;
  always_comb begin
    state_nx = flush ? IDLE : acc ? SEND : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      sym_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      if (acc) hold <= cw_in;
      sym_idx <= (flush || acc) ? '0 : (xfer && !sym_last) ? sym_idx + 1'b1 : sym_idx;
      if (done && !flush) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: doc/bpsk_tx_sched.md
BPSK_TX_SCHED -- requirements
Module: bpsk_tx_sched

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the codeword length in bits; legal values are 4 and 8.
REQ-002 The block SHALL have parameter SIZE, default 8, giving the signed symbol width in bits; SIZE SHALL be at least 2.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, width 1: synchronous abort of the current frame.
REQ-006 The block SHALL have port cw_in, input, width N: codeword; bit i is transmitted as symbol i.
REQ-007 The block SHALL have port cw_valid, input, width 1: cw_in is valid.
REQ-008 The block SHALL have port cw_ready, output, width 1: the block accepts cw_in this cycle.
REQ-009 The block SHALL have port sym_out, output, width SIZE, signed: the BPSK symbol.
REQ-010 The block SHALL have port sym_valid, output, width 1: sym_out is valid.
REQ-011 The block SHALL have port sym_ready, input, width 1: the downstream block accepts sym_out.
REQ-012 The block SHALL have port sym_idx, output, width clog2(N): index of the current symbol within its frame.
REQ-013 The block SHALL have port sym_last, output, width 1: the current symbol is symbol N-1.
REQ-014 The block SHALL have port busy, output, width 1: a frame is held in the block.
REQ-015 The block SHALL have port frame_cnt, output, width 16: count of fully transmitted frames.

Function
REQ-016 The block SHALL implement a two-state FSM with states IDLE and SEND.
REQ-017 An accept SHALL occur on a rising edge where cw_valid=1 and cw_ready=1; on accept, cw_in SHALL be latched into an N-bit holding register, the symbol index SHALL be set to 0, and the FSM SHALL enter SEND.
REQ-018 cw_ready SHALL equal (state==IDLE or (state==SEND and sym_last and sym_ready)) and not flush and not rst.
REQ-019 In SEND, sym_valid SHALL be 1; in IDLE, sym_valid SHALL be 0.
REQ-020 sym_out SHALL be +1 (all bits 0 except LSB) when the held bit at sym_idx is 0.
REQ-021 sym_out SHALL be -1 (all bits 1, two's complement) when the held bit at sym_idx is 1.
REQ-022 sym_out SHALL be 0 whenever sym_valid=0.
REQ-023 Latency SHALL be one cycle: symbol 0 is valid in the cycle after the accept edge.
REQ-024 A transfer SHALL occur on an edge where sym_valid=1 and sym_ready=1; on a transfer with sym_idx<N-1, sym_idx SHALL increment by 1.
REQ-025 While sym_valid=1 and sym_ready=0, sym_out, sym_idx and sym_last SHALL hold stable.
REQ-026 On a transfer with sym_idx=N-1, frame_cnt SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-027 On a transfer with sym_idx=N-1 and cw_valid=1 at the same edge, a new frame SHALL be accepted and the FSM SHALL remain in SEND with sym_idx=0, giving zero bubble cycles.
REQ-028 On a transfer with sym_idx=N-1 and cw_valid=0 at the same edge, the FSM SHALL go to IDLE.
REQ-029 A full frame SHALL take exactly N transfers; the throughput SHALL be 1 symbol per cycle when sym_ready is held at 1.
REQ-030 When flush=1 at an edge, the FSM SHALL go to IDLE and sym_idx SHALL clear to 0.
REQ-031 During flush, frame_cnt SHALL NOT increment, even if the last symbol is transferred on the same edge.
REQ-032 During flush, no frame SHALL be accepted.
REQ-033 busy SHALL equal (state==SEND).
REQ-034 The holding register SHALL change only on an accept.

Reset
REQ-035 When rst=1 at an edge, the FSM SHALL go to IDLE and sym_idx, frame_cnt and the holding register SHALL clear to 0.
REQ-036 rst SHALL take priority over flush, accept and transfer at the same edge.
REQ-037 While rst=1, outputs SHALL be: cw_ready=0, sym_valid=0, sym_out=0, sym_last=0, busy=0.
REQ-038 In the first cycle after reset deasserts, cw_ready SHALL be 1.
REQ-039 rst asserted mid-frame SHALL abandon the frame with no partial frame_cnt increment.

Verification (N=4, SIZE=8)
REQ-040 The bench SHALL cover a single frame: cw_in=4'b0110 accepted with sym_ready=1 -> sym_out sequence 0x01, 0xFF, 0xFF, 0x01; sym_idx 0..3; sym_last only on idx 3; frame_cnt=1; IDLE afterwards.
REQ-041 The bench SHALL cover back-to-back frames: frames 4'b1111 then 4'b0000 with cw_valid held high -> 8 consecutive valid cycles (0xFF x4, then 0x01 x4); cw_ready=1 only on the idx-3 cycle; frame_cnt=2.
REQ-042 The bench SHALL cover backpressure: sym_ready=0 for 3 cycles at idx 1 of frame 4'b0010 -> sym_out=0xFF and sym_idx=1 held stable for all 3 cycles; cw_ready=0 throughout.
REQ-043 The bench SHALL cover flush: flush pulsed at idx 2 -> IDLE next cycle; sym_valid=0; frame_cnt unchanged; the next frame starts at idx 0.
REQ-044 The bench SHALL cover reset mid-frame: rst at idx 1 with frame_cnt=5 -> frame_cnt=0, sym_valid=0, cw_ready=0 while rst=1, cw_ready=1 the cycle after release.
REQ-045 The bench SHALL cover frame_cnt wrap: frame_cnt preloaded by driving 65535 frames -> the next completed frame gives frame_cnt=0x0000.
